// File: rtl/rom_port.sv
// ----------------------------------------------------------------------------
// rom_port
//
// Registered, read-only instruction/data memory port with a valid/ready
// handshake on both the request and the response side. Each accepted request
// is answered exactly LATENCY cycles later with a registered response that
// stays put until the consumer takes it. Byte and halfword loads are lane
// selected and sign- or zero-extended. Out-of-range, misaligned and
// reserved-size accesses return an error with zero data; they use the same
// timing and handshake as good accesses.
//
// Parameters
//   ADDR_WIDTH  word-address bits, depth = 2**ADDR_WIDTH 32-bit words
//   BASE_ADDR   byte address of word 0 (4-byte aligned)
//   LATENCY     cycles from request accept to rsp_valid (1..8)
//   INIT_FILE   name of the program image supplied by the environment
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous, active-low reset
//   req_valid     request present
//   req_ready     port is idle and can accept a request
//   req_addr      byte address
//   req_size      0 = byte, 1 = half, 2 = word, 3 = reserved
//   req_unsigned  1 = zero-extend sub-word data, 0 = sign-extend
//   rsp_valid     response present
//   rsp_ready     consumer accepts the response
//   rsp_data      extended read data (zero on error)
//   rsp_err       access fault (range, alignment or reserved size)
// ----------------------------------------------------------------------------
module rom_port #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 1,
    parameter string       INIT_FILE  = "prog.hex"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Number of extra WAIT cycles after the first one; unused when LATENCY==1.
    localparam logic [2:0] WAIT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t      state;
    state_t      state_next;
    logic [2:0]  count;
    logic [2:0]  count_next;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        unsigned_q;

    logic        accept;
    logic        load_rsp;

    logic [31:0] src_addr;
    logic [1:0]  src_size;
    logic        src_unsigned;
    logic [31:0] off;
    logic        range_err;
    logic        align_err;
    logic        access_err;
    logic [31:0] rd_word;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] ext_data;

    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= 3'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state logic. The counter is preloaded on accept and walks down
    // to zero; the WAIT state is left on the cycle it reads zero.
    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        count_next = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (count == 3'd0) begin
                    state_next = RESP;
                end else begin
                    count_next = count - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = 3'd0;
            end
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    assign accept   = req_valid && (state == IDLE);
    assign load_rsp = (state != RESP) && (state_next == RESP);

    // With LATENCY==1 the response is loaded on the accept edge itself, so
    // the decode must see the live request; otherwise the latched copy.
    always_comb begin
        src_addr     = (state == IDLE) ? req_addr     : addr_q;
        src_size     = (state == IDLE) ? req_size     : size_q;
        src_unsigned = (state == IDLE) ? req_unsigned : unsigned_q;

        // Wrapping subtraction makes addresses below the base look huge,
        // so one compare covers both ends of the window.
        off       = src_addr - BASE_ADDR;
        range_err = (off >> (ADDR_WIDTH + 2)) != 32'd0;
        rd_word   = mem[off[ADDR_WIDTH+1:2]];

        // The base is word aligned, so offset low bits equal address low bits.
        unique case (src_size)
            2'd0:    align_err = 1'b0;
            2'd1:    align_err = off[0];
            2'd2:    align_err = |off[1:0];
            default: align_err = 1'b1;
        endcase
        access_err = range_err || align_err;

        byte_lane = rd_word[{off[1:0], 3'b000} +: 8];
        half_lane = rd_word[{off[1], 4'b0000} +: 16];

        unique case (src_size)
            2'd0:    ext_data = src_unsigned ? {24'h0, byte_lane}
                                             : {{24{byte_lane[7]}}, byte_lane};
            2'd1:    ext_data = src_unsigned ? {16'h0, half_lane}
                                             : {{16{half_lane[15]}}, half_lane};
            default: ext_data = rd_word;
        endcase

        if (access_err) begin
            ext_data = 32'h0;
        end
    end

    // Request capture and response register. The response is only written
    // on entry to RESP, which keeps it stable through any backpressure and
    // after the handshake until the next load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= 32'h0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            rsp_data   <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q     <= req_addr;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
            end
            if (load_rsp) begin
                rsp_data <= ext_data;
                rsp_err  <= access_err;
            end
        end
    end

endmodule

// File: tb/tb_rom_port.sv
// ----------------------------------------------------------------------------
// tb_rom_port
//
// Three rom_port instances with different latency/base settings share one
// clock. Each has its own request, response and reset signals. Expected
// responses come from a behavioural model of the memory image and are queued
// per channel on accept; a monitor pops them when a response appears and also
// checks latency, hold-under-backpressure and ready recovery.
// ----------------------------------------------------------------------------
module tb_rom_port;

    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;
    localparam int NCH   = 3;

    localparam int          LAT  [NCH] = '{1, 3, 4};
    localparam logic [31:0] BASE [NCH] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0] rst_n;
    logic [NCH-1:0] req_valid;
    logic [NCH-1:0] req_ready;
    logic [NCH-1:0] req_unsigned;
    logic [NCH-1:0] rsp_valid;
    logic [NCH-1:0] rsp_ready;
    logic [NCH-1:0] rsp_err;
    logic [31:0]    req_addr [NCH];
    logic [1:0]     req_size [NCH];
    logic [31:0]    rsp_data [NCH];

    logic [31:0]    img [NCH][DEPTH];
    exp_t           sb  [NCH][$];

    bit   [NCH-1:0] rdy_force;
    bit   [NCH-1:0] rdy_val;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    rom_port #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE[0]), .LATENCY(LAT[0]), .INIT_FILE("")) u_lat1 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0])
    );

    rom_port #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE[1]), .LATENCY(LAT[1]), .INIT_FILE("")) u_lat3 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1])
    );

    rom_port #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE[2]), .LATENCY(LAT[2]), .INIT_FILE("")) u_lat4 (
        .clk(clk), .rst_n(rst_n[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
        .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_data(rsp_data[2]), .rsp_err(rsp_err[2])
    );

    // One counted comparison; prints a FAIL line on mismatch.
    task automatic check_output(string name, int ch, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s ch%0d cyc%0d: got %h, expected %h", name, ch, cyc, act, exp);
        end
    endtask

    // Reference: byte-addressed view of the image with the load rules applied.
    function automatic exp_t model(int ch, logic [31:0] addr, logic [1:0] size, logic uns);
        exp_t        e;
        int unsigned a;
        int unsigned off;
        int unsigned w;
        int unsigned v;
        a      = addr;
        off    = addr - BASE[ch];
        e.data = 32'h0;
        e.err  = 1'b0;
        e.acc  = 0;
        if (off >= 4 * DEPTH || size == 2'd3 ||
            (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0)) begin
            e.err = 1'b1;
            return e;
        end
        w = img[ch][off / 4];
        case (size)
            2'd0: begin
                v = (w >> (8 * (a % 4))) % 256;
                if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (w >> (16 * ((a / 2) % 2))) % 65536;
                if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        e.data = v;
        return e;
    endfunction

    // Present a request, wait for acceptance, queue its expected response,
    // then scramble the request inputs to show they are no longer sampled.
    task automatic apply_stimulus(int ch, logic [31:0] addr, logic [1:0] size, logic uns,
                                  bit use_exp, logic [31:0] exp_data, logic exp_err);
        exp_t e;
        int   waited;
        bit   ok;
        e = model(ch, addr, size, uns);
        if (use_exp) begin
            e.data = exp_data;
            e.err  = exp_err;
        end
        @(posedge clk); #1;
        req_valid[ch]    = 1'b1;
        req_addr[ch]     = addr;
        req_size[ch]     = size;
        req_unsigned[ch] = uns;
        waited = 0;
        ok     = 1'b0;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (req_ready[ch] && rst_n[ch]) ok = 1'b1;
            else waited++;
        end
        if (ok) begin
            e.acc = cyc;
            sb[ch].push_back(e);
        end else begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL accept_timeout ch%0d: req_ready stayed %0b, expected 1", ch, req_ready[ch]);
        end
        @(posedge clk); #1;
        req_valid[ch]    = 1'b0;
        req_addr[ch]     = $urandom;
        req_size[ch]     = 2'($urandom);
        req_unsigned[ch] = 1'($urandom);
    endtask

    // Response consumer: random readiness unless a test forces a level.
    initial begin
        rsp_ready = '1;
        forever begin
            @(posedge clk); #1;
            for (int ch = 0; ch < NCH; ch++) begin
                rsp_ready[ch] = rdy_force[ch] ? rdy_val[ch] : ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: pops the scoreboard on each new response and checks the
    // response protocol around it.
    initial begin : monitor
        bit   [NCH-1:0] prev_valid;
        bit   [NCH-1:0] hs_pend;
        logic [31:0]    held_data [NCH];
        logic           held_err  [NCH];
        exp_t           e;
        prev_valid = '0;
        hs_pend    = '0;
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) begin
                if (!rst_n[ch]) begin
                    prev_valid[ch] = 1'b0;
                    hs_pend[ch]    = 1'b0;
                    continue;
                end
                if (hs_pend[ch]) begin
                    check_output("ready_after_hs", ch, 32'(req_ready[ch]), 32'd1);
                    check_output("valid_drop_after_hs", ch, 32'(rsp_valid[ch]), 32'd0);
                    hs_pend[ch] = 1'b0;
                end
                if (rsp_valid[ch]) begin
                    check_output("req_ready_in_resp", ch, 32'(req_ready[ch]), 32'd0);
                    if (!prev_valid[ch]) begin
                        if (sb[ch].size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("[TB] FAIL unexpected_rsp ch%0d: got rsp_valid 1, expected no response", ch);
                        end else begin
                            e = sb[ch].pop_front();
                            check_output("rsp_data", ch, rsp_data[ch], e.data);
                            check_output("rsp_err", ch, 32'(rsp_err[ch]), 32'(e.err));
                            check_output("latency", ch, cyc - e.acc, LAT[ch]);
                        end
                    end else begin
                        check_output("hold_data", ch, rsp_data[ch], held_data[ch]);
                        check_output("hold_err", ch, 32'(rsp_err[ch]), 32'(held_err[ch]));
                    end
                    held_data[ch] = rsp_data[ch];
                    held_err[ch]  = rsp_err[ch];
                    if (rsp_ready[ch]) hs_pend[ch] = 1'b1;
                end
                prev_valid[ch] = rsp_valid[ch];
            end
        end
    end

    // Run-time bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int          waited;
        int          r;
        logic [31:0] addr;

        rdy_force    = '0;
        rdy_val      = '1;
        rst_n        = '0;
        req_valid    = '0;
        req_unsigned = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            req_addr[ch] = 32'h0;
            req_size[ch] = 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                img[ch][i] = (i == 0) ? 32'h8001_7F02 : $urandom;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            u_lat1.mem[i] = img[0][i];
            u_lat3.mem[i] = img[1][i];
            u_lat4.mem[i] = img[2][i];
        end

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #1 rst_n = '1;
        @(negedge clk);
        for (int ch = 0; ch < NCH; ch++) begin
            check_output("reset_req_ready", ch, 32'(req_ready[ch]), 32'd1);
            check_output("reset_rsp_valid", ch, 32'(rsp_valid[ch]), 32'd0);
            check_output("reset_rsp_data", ch, rsp_data[ch], 32'h0);
            check_output("reset_rsp_err", ch, 32'(rsp_err[ch]), 32'd0);
        end

        $display("[TB] lane select and extension, latency 1");
        apply_stimulus(0, 32'd0, 2'd2, 1'b0, 1'b1, 32'h8001_7F02, 1'b0);
        apply_stimulus(0, 32'd1, 2'd0, 1'b0, 1'b1, 32'h0000_007F, 1'b0);
        apply_stimulus(0, 32'd3, 2'd0, 1'b0, 1'b1, 32'hFFFF_FF80, 1'b0);
        apply_stimulus(0, 32'd2, 2'd1, 1'b1, 1'b1, 32'h0000_8001, 1'b0);
        apply_stimulus(0, 32'd2, 2'd1, 1'b0, 1'b1, 32'hFFFF_8001, 1'b0);
        apply_stimulus(0, 32'd0, 2'd1, 1'b0, 1'b1, 32'h0000_7F02, 1'b0);
        apply_stimulus(0, 32'd3, 2'd0, 1'b1, 1'b1, 32'h0000_0080, 1'b0);
        apply_stimulus(0, 32'd64, 2'd2, 1'b0, 1'b1, 32'h0, 1'b1);

        $display("[TB] faults and base offset, latency 3");
        apply_stimulus(1, BASE[1] + 32'd1, 2'd1, 1'b0, 1'b1, 32'h0, 1'b1);
        apply_stimulus(1, BASE[1] + 32'd64, 2'd2, 1'b0, 1'b1, 32'h0, 1'b1);
        apply_stimulus(1, BASE[1], 2'd3, 1'b0, 1'b1, 32'h0, 1'b1);
        apply_stimulus(1, 32'h8000_0004, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1, 32'h7FFF_FFFC, 2'd2, 1'b0, 1'b1, 32'h0, 1'b1);
        apply_stimulus(1, BASE[1] + 32'd6, 2'd2, 1'b0, 1'b1, 32'h0, 1'b1);
        apply_stimulus(2, 32'd64, 2'd2, 1'b0, 1'b1, 32'h0, 1'b1);

        $display("[TB] backpressure");
        rdy_force[1] = 1'b1;
        rdy_val[1]   = 1'b0;
        apply_stimulus(1, BASE[1] + 32'd8, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        waited = 0;
        while (!rsp_valid[1] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output("bp_rsp_seen", 1, 32'(rsp_valid[1]), 32'd1);
        @(posedge clk); #1;
        req_valid[1]    = 1'b1;
        req_addr[1]     = BASE[1] + 32'd12;
        req_size[1]     = 2'd2;
        req_unsigned[1] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_output("bp_req_ready_low", 1, 32'(req_ready[1]), 32'd0);
        end
        rdy_val[1] = 1'b1;
        apply_stimulus(1, BASE[1] + 32'd12, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        rdy_force[1] = 1'b0;

        $display("[TB] reset during wait, latency 4");
        apply_stimulus(2, 32'd4, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
        rst_n[2] = 1'b0;
        sb[2].delete();
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        @(negedge clk);
        check_output("rst_wait_req_ready", 2, 32'(req_ready[2]), 32'd1);
        repeat (10) begin
            check_output("rst_wait_no_rsp", 2, 32'(rsp_valid[2]), 32'd0);
            @(negedge clk);
        end
        apply_stimulus(2, 32'd8, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("[TB] randomized traffic");
        for (int ch = 0; ch < NCH; ch++) begin
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                if (r < 7)      addr = BASE[ch] + $urandom_range(0, 4 * DEPTH - 1);
                else if (r < 8) addr = BASE[ch] + 4 * DEPTH + $urandom_range(0, 15);
                else if (r < 9) addr = BASE[ch] - $urandom_range(1, 16);
                else            addr = $urandom;
                apply_stimulus(ch, addr, 2'($urandom_range(0, 3)), 1'($urandom), 1'b0, 32'h0, 1'b0);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            end
        end

        waited = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        for (int ch = 0; ch < NCH; ch++) begin
            check_output("drain", ch, sb[ch].size(), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
